power_rail_sequencer: RTL
=========================

// Module: power_rail_sequencer
// PURPOSE
//   Sequences N_RAILS supply rails of the PMIC for power-up and power-down.
//   Power-up enables rails in ascending index order. Each rail must report
//   power-good within a timeout, then a fixed settling delay elapses before
//   the next rail is enabled. Power-down disables rails in descending order.
//   Rail power-good is monitored continuously; a timeout or brown-out latches
//   a fault and drops all rails. Sits between system power control and the
//   per-rail regulator enables/PG lines.
// PARAMETERS
//   N_RAILS     4     number of sequenced rails (>=1)
//   PG_TIMEOUT  1000  cycles allowed from rail enable to rail_pg high (>=1)
//   STEP_DELAY  100   settling cycles between rail steps, up and down (>=1)
//   CNT_W       16    counter width; must hold max(PG_TIMEOUT,STEP_DELAY)
//   IDX_W       (N_RAILS>1 ? $clog2(N_RAILS) : 1), derived localparam
// PORTS
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   power_on     in   1        level request: 1 = rails up, 0 = rails down
//   rail_pg      in   N_RAILS  per-rail power-good, already synchronised to clk
//   clear_fault  in   1        fault clear; honoured only when power_on=0
//   rail_en      out  N_RAILS  per-rail regulator enable, registered
//   power_good   out  1        all rails up and settled, registered
//   busy         out  1        sequencing in progress (up or down)
//   fault        out  1        latched fault
//   fault_rail   out  IDX_W    index of faulting rail, valid while fault=1
// BEHAVIOUR
//   Reset: state=OFF. rail_en=0, power_good=0, busy=0, fault=0, fault_rail=0.
//     Index and counter are cleared. Reset overrides everything, including
//     mid-sequence; no reverse-order shutdown occurs on reset.
//   States: OFF, UP_WAIT, UP_DELAY, ON, DN_DELAY, FAULT. All outputs registered.
//   OFF: when power_on=1 -> rail_en[0]<=1, idx<=0, cnt<=0, go to UP_WAIT.
//   UP_WAIT: each cycle, evaluate in this priority order:
//     (a) Any enabled rail j<idx has rail_pg[j]=0 -> FAULT, fault_rail<=lowest such j.
//     (b) power_on=0 -> rail_en[idx]<=0, go to DN_DELAY (unwind from idx).
//     (c) rail_pg[idx]=1 -> cnt<=0, go to UP_DELAY.
//     (d) cnt==PG_TIMEOUT-1 -> FAULT, fault_rail<=idx.
//     (e) Otherwise cnt++.
//     Timeout therefore fires on the PG_TIMEOUT-th cycle in UP_WAIT without PG.
//   UP_DELAY: check for brown-out on rails 0..idx first (same rule as (a)),
//     then power_on=0 (same as (b)). Otherwise, when cnt==STEP_DELAY-1:
//     - idx==N_RAILS-1 -> ON, power_good<=1.
//     - else idx++, rail_en[idx+1]<=1, cnt<=0, go to UP_WAIT.
//     Any other cycle: cnt++.
//   ON: power_good=1.
//     - Any rail_pg=0 -> FAULT (lowest index); takes priority over power_on=0.
//     - power_on=0 -> power_good<=0, rail_en[N_RAILS-1]<=0, idx<=N_RAILS-1,
//       cnt<=0, go to DN_DELAY. power_good falls on the same edge as the
//       top rail's enable.
//   DN_DELAY: rail_pg is ignored. When cnt==STEP_DELAY-1:
//     - idx==0 -> OFF.
//     - else idx--, rail_en[idx-1]<=0, cnt<=0.
//     power_on re-assertion is ignored until OFF is reached (then restarts).
//   FAULT: on entry rail_en<=0, power_good<=0, fault<=1. State and fault_rail
//     hold until clear_fault=1 && power_on=0, which sets fault<=0 and goes to
//     OFF. clear_fault while power_on=1 has no effect.
//   busy=1 in UP_WAIT, UP_DELAY and DN_DELAY; 0 otherwise.
//   rail_en is always a thermometer code (rails 0..k set), except all-0 in FAULT.
// TESTING (N_RAILS=4, PG_TIMEOUT=8, STEP_DELAY=4; each rail_pg follows its
//   rail_en after 2 cycles unless stated otherwise)
//   1. power_on=1 from OFF -> rail_en 0001,0011,0111,1111, each step 7 cycles
//      apart; power_good=1 after the final delay; busy=0 in ON.
//   2. rail_pg[2] held 0 -> 8 cycles after rail_en[2] rises: fault=1,
//      fault_rail=2, rail_en=0000, power_good=0.
//   3. In ON, drop power_on -> rail_en 0111,0011,0001,0000, 4 cycles apart;
//      power_good=0 on the same edge as 0111; state returns to OFF.
//   4. In ON, pulse rail_pg[1]=0 for 1 cycle -> fault=1, fault_rail=1,
//      rail_en=0. clear_fault with power_on=1 is ignored; clear_fault with
//      power_on=0 -> OFF.
//   5. power_on drops during UP_WAIT of rail 1 -> rail_en 0001 then 0000 after
//      4 cycles; no fault raised.
//   6. Assert reset mid-power-up (rail_en=0011) -> next cycle all outputs at
//      reset values; power_on=1 restarts cleanly from rail 0.

Source files
------------

// File: rtl/power_rail_sequencer.sv
// power_rail_sequencer: ordered power-up/down of N_RAILS supply rails with PG timeout and brown-out fault latching
module power_rail_sequencer #(
  parameter int N_RAILS = 4,
  parameter int PG_TIMEOUT = 1000,
  parameter int STEP_DELAY = 100,
  parameter int CNT_W = 16,
  localparam int IDX_W = (N_RAILS > 1) ? $clog2(N_RAILS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               power_on,
  input  logic [N_RAILS-1:0] rail_pg,
  input  logic               clear_fault,
  output logic [N_RAILS-1:0] rail_en,
  output logic               power_good,
  output logic               busy,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_rail
);
  typedef enum logic [2:0] {OFF, UP_WAIT, UP_DELAY, ON, DN_DELAY, FAULT} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, fault_rail_q, fault_rail_d, low;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d, bad;
  logic power_good_q, power_good_d, fault_q, fault_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      idx_q <= '0;
      cnt_q <= '0;
      rail_en_q <= '0;
      power_good_q <= 1'b0;
      fault_q <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rail_en_q <= rail_en_d;
      power_good_q <= power_good_d;
      fault_q <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end
  // rail_en is a thermometer code, so shifting it drops/adds exactly the top rail
  always_comb begin
    bad = ~rail_pg & (state_q == UP_WAIT ? rail_en_q >> 1 : rail_en_q);
    low = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) if (bad[i]) low = IDX_W'(i);
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rail_en_d = rail_en_q;
    power_good_d = power_good_q;
    fault_d = fault_q;
    fault_rail_d = fault_rail_q;
    case (state_q)
      OFF: if (power_on) begin
        rail_en_d = N_RAILS'(1);
        idx_d = '0;
        cnt_d = '0;
        state_d = UP_WAIT;
      end
      UP_WAIT, UP_DELAY: if (|bad) begin
        fault_rail_d = low;
        state_d = FAULT;
      end else if (!power_on) begin
        rail_en_d = rail_en_q >> 1;
        cnt_d = '0;
        state_d = DN_DELAY;
      end else if (state_q == UP_WAIT) begin
        if (rail_pg[idx_q]) begin
          cnt_d = '0;
          state_d = UP_DELAY;
        end else if (cnt_q == CNT_W'(PG_TIMEOUT - 1)) begin
          fault_rail_d = idx_q;
          state_d = FAULT;
        end else cnt_d = cnt_q + CNT_W'(1);
      end else if (cnt_q == CNT_W'(STEP_DELAY - 1)) begin
        if (idx_q == IDX_W'(N_RAILS - 1)) begin
          power_good_d = 1'b1;
          state_d = ON;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          rail_en_d = (rail_en_q << 1) | N_RAILS'(1);
          cnt_d = '0;
          state_d = UP_WAIT;
        end
      end else cnt_d = cnt_q + CNT_W'(1);
      ON: if (|bad) begin
        fault_rail_d = low;
        state_d = FAULT;
      end else if (!power_on) begin
        power_good_d = 1'b0;
        rail_en_d = rail_en_q >> 1;
        idx_d = IDX_W'(N_RAILS - 1);
        cnt_d = '0;
        state_d = DN_DELAY;
      end
      DN_DELAY: if (cnt_q == CNT_W'(STEP_DELAY - 1)) begin
        if (idx_q == '0) state_d = OFF;
        else begin
          idx_d = idx_q - IDX_W'(1);
          rail_en_d = rail_en_q >> 1;
          cnt_d = '0;
        end
      end else cnt_d = cnt_q + CNT_W'(1);
      FAULT: if (clear_fault && !power_on) begin
        fault_d = 1'b0;
        state_d = OFF;
      end
      default: state_d = OFF;
    endcase
    if (state_d == FAULT && state_q != FAULT) begin
      rail_en_d = '0;
      power_good_d = 1'b0;
      fault_d = 1'b1;
    end
  end
  assign rail_en = rail_en_q;
  assign power_good = power_good_q;
  assign fault = fault_q;
  assign fault_rail = fault_rail_q;
  assign busy = state_q == UP_WAIT || state_q == UP_DELAY || state_q == DN_DELAY;
endmodule
